// File: rtl/pc_pkg.sv
// Shared types and helpers for the fetch-PC predictor: BTB entry layout and 2-bit counter encoding.
package pc_pkg;

    // Storage width for tag/target fields; the PC width must not exceed it.
    localparam int PC_MAX_W = 32;

    localparam logic [1:0] CNT_SNT = 2'b00;
    localparam logic [1:0] CNT_WNT = 2'b01;
    localparam logic [1:0] CNT_WT  = 2'b10;
    localparam logic [1:0] CNT_ST  = 2'b11;

    typedef struct packed {
        logic                valid;
        logic [PC_MAX_W-1:0] tag;
        logic [PC_MAX_W-1:0] target;
        logic [1:0]          counter;
    } btb_entry_t;

    function automatic logic [1:0] sat_update(input logic [1:0] counter, input logic taken);
        if (taken) begin
            return (counter == CNT_ST) ? CNT_ST : counter + 2'd1;
        end
        return (counter == CNT_SNT) ? CNT_SNT : counter - 2'd1;
    endfunction

endpackage

// File: rtl/pc_btb.sv
// Direct-mapped branch target buffer: combinational lookup on the word address of the fetch PC,
// single-port update/allocation from execute. Only valid bits are reset.
module pc_btb
    import pc_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 32,
    parameter int BTB_ENTRIES   = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [ADDRESS_WIDTH-3:0] lookup_word,
    output logic                     hit_taken,
    output logic [ADDRESS_WIDTH-1:0] hit_target,
    input  logic                     update_valid,
    input  logic [ADDRESS_WIDTH-3:0] update_word,
    input  logic [ADDRESS_WIDTH-1:0] update_target,
    input  logic                     update_taken
);

    localparam int IDX = $clog2(BTB_ENTRIES);

    btb_entry_t mem [BTB_ENTRIES];

    logic [IDX-1:0]      lk_idx;
    logic [IDX-1:0]      up_idx;
    logic [PC_MAX_W-1:0] lk_tag;
    logic [PC_MAX_W-1:0] up_tag;
    btb_entry_t          lk_e;
    btb_entry_t          up_e;
    btb_entry_t          up_next;
    logic                up_hit;
    logic                up_write;

    // Tags are stored zero-extended so the full field takes part in the compare.
    assign lk_idx = lookup_word[IDX-1:0];
    assign up_idx = update_word[IDX-1:0];
    assign lk_tag = PC_MAX_W'(lookup_word[ADDRESS_WIDTH-3:IDX]);
    assign up_tag = PC_MAX_W'(update_word[ADDRESS_WIDTH-3:IDX]);

    always_comb begin
        lk_e       = mem[lk_idx];
        hit_taken  = lk_e.valid && (lk_e.tag == lk_tag) && lk_e.counter[1];
        hit_target = lk_e.target[ADDRESS_WIDTH-1:0];
    end

    always_comb begin
        up_e     = mem[up_idx];
        up_hit   = up_e.valid && (up_e.tag == up_tag);
        up_next  = up_e;
        up_write = 1'b0;
        if (update_valid) begin
            if (up_hit) begin
                up_write        = 1'b1;
                up_next.counter = sat_update(up_e.counter, update_taken);
                if (update_taken) begin
                    up_next.target = PC_MAX_W'(update_target);
                end
            end else if (update_taken) begin
                up_write        = 1'b1;
                up_next.valid   = 1'b1;
                up_next.tag     = up_tag;
                up_next.target  = PC_MAX_W'(update_target);
                up_next.counter = CNT_WT;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                mem[i].valid <= 1'b0;
            end
        end else if (up_write) begin
            mem[up_idx] <= up_next;
        end
    end

endmodule

// File: rtl/pc_predict.sv
// Fetch PC register with next-PC selection: redirect > stall > BTB prediction > pc+4.
// The BTB is present only when PC_PREDICT_BTB_EN is defined.
module pc_predict
    import pc_pkg::*;
#(
    parameter int                     ADDRESS_WIDTH = 32,
    parameter int                     BTB_ENTRIES   = 16,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_VECTOR  = 32'hBFC0_0000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en_n,
    input  logic                     redirect,
    input  logic [ADDRESS_WIDTH-1:0] redirect_pc,
    input  logic                     update_valid,
    input  logic [ADDRESS_WIDTH-1:0] update_pc,
    input  logic [ADDRESS_WIDTH-1:0] update_target,
    input  logic                     update_taken,
    output logic [ADDRESS_WIDTH-1:0] pc,
    output logic [ADDRESS_WIDTH-1:0] pcplus4,
    output logic                     pred_taken,
    output logic [ADDRESS_WIDTH-1:0] pred_target
);

    logic [ADDRESS_WIDTH-1:0] next_pc;

    assign pcplus4 = pc + ADDRESS_WIDTH'(4);

`ifdef PC_PREDICT_BTB_EN
    logic                     hit_taken;
    logic [ADDRESS_WIDTH-1:0] hit_target;
    logic                     unused_low_bits;

    pc_btb #(
        .ADDRESS_WIDTH(ADDRESS_WIDTH),
        .BTB_ENTRIES  (BTB_ENTRIES)
    ) u_btb (
        .clk          (clk),
        .rst_n        (rst_n),
        .lookup_word  (pc[ADDRESS_WIDTH-1:2]),
        .hit_taken    (hit_taken),
        .hit_target   (hit_target),
        .update_valid (update_valid),
        .update_word  (update_pc[ADDRESS_WIDTH-1:2]),
        .update_target(update_target),
        .update_taken (update_taken)
    );

    assign pred_taken      = hit_taken;
    assign pred_target     = hit_taken ? hit_target : pcplus4;
    assign unused_low_bits = ^update_pc[1:0];
`else
    logic unused_update;

    assign pred_taken    = 1'b0;
    assign pred_target   = pcplus4;
    assign unused_update = ^{update_valid, update_pc, update_target, update_taken, BTB_ENTRIES[0]};
`endif

    always_comb begin
        next_pc = pcplus4;
        if (redirect) begin
            next_pc = redirect_pc;
        end else if (en_n) begin
            next_pc = pc;
        end else if (pred_taken) begin
            next_pc = pred_target;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_VECTOR;
        end else begin
            pc <= next_pc;
        end
    end

endmodule

// File: tb/tb_pc_predict.sv
// Directed bench for pc_predict; expectations follow PC_PREDICT_BTB_EN (no BTB means never predicted).
module tb_pc_predict;

`ifdef PC_PREDICT_BTB_EN
    localparam bit BTB = 1'b1;
`else
    localparam bit BTB = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en_n;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        update_valid;
    logic [31:0] update_pc;
    logic [31:0] update_target;
    logic        update_taken;
    logic [31:0] pc;
    logic [31:0] pcplus4;
    logic        pred_taken;
    logic [31:0] pred_target;

    int tests_run    = 0;
    int tests_failed = 0;

    pc_predict #(
        .ADDRESS_WIDTH(32),
        .BTB_ENTRIES  (16),
        .RESET_VECTOR (32'hBFC0_0000)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en_n         (en_n),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .update_valid (update_valid),
        .update_pc    (update_pc),
        .update_target(update_target),
        .update_taken (update_taken),
        .pc           (pc),
        .pcplus4      (pcplus4),
        .pred_taken   (pred_taken),
        .pred_target  (pred_target)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    // Inputs are driven and outputs sampled at the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic jump(input logic [31:0] a);
        redirect    = 1'b1;
        redirect_pc = a;
        step();
        redirect    = 1'b0;
    endtask

    task automatic do_update(input logic [31:0] upc, input logic [31:0] tgt, input logic tk);
        update_valid  = 1'b1;
        update_pc     = upc;
        update_target = tgt;
        update_taken  = tk;
        step();
        update_valid  = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] exp_pc;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (pc !== 32'hBFC0_0000) begin
            tests_failed++;
            $display("FAIL reset_pc got %h want %h", pc, 32'hBFC0_0000);
        end
        tests_run++;
        if (pcplus4 !== 32'hBFC0_0004 || pred_taken !== 1'b0 || pred_target !== 32'hBFC0_0004) begin
            tests_failed++;
            $display("FAIL reset_outputs got p4=%h pt=%b tgt=%h want p4=bfc00004 pt=0 tgt=bfc00004",
                     pcplus4, pred_taken, pred_target);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        en_n  = 1'b0;
        exp_pc = 32'hBFC0_0000;
        for (int i = 0; i < 3; i++) begin
            step();
            exp_pc = exp_pc + 32'd4;
            tests_run++;
            if (pc !== exp_pc) begin
                tests_failed++;
                $display("FAIL free_run_%0d got %h want %h", i, pc, exp_pc);
            end
        end
        en_n = 1'b1;
    endtask

    task automatic test_btb_alloc();
        en_n = 1'b1;
        do_update(32'h100, 32'h200, 1'b1);
        jump(32'h100);
        tests_run++;
        if (pc !== 32'h100 || pcplus4 !== 32'h104) begin
            tests_failed++;
            $display("FAIL alloc_pc got pc=%h p4=%h want pc=00000100 p4=00000104", pc, pcplus4);
        end
        tests_run++;
        if (pred_taken !== BTB || pred_target !== (BTB ? 32'h200 : 32'h104)) begin
            tests_failed++;
            $display("FAIL alloc_pred got pt=%b tgt=%h want pt=%b tgt=%h",
                     pred_taken, pred_target, BTB, BTB ? 32'h200 : 32'h104);
        end
        en_n = 1'b0;
        step();
        en_n = 1'b1;
        tests_run++;
        if (pc !== (BTB ? 32'h200 : 32'h104)) begin
            tests_failed++;
            $display("FAIL alloc_next_pc got %h want %h", pc, BTB ? 32'h200 : 32'h104);
        end
    endtask

    // Starting from counter 10 / target 0x200 at 0x100.
    task automatic test_counter();
        bit          tk_tbl [9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        bit          pt_tbl [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [31:0] exp_tgt;
        logic        exp_pt;
        en_n = 1'b1;
        jump(32'h100);
        for (int i = 0; i < 9; i++) begin
            do_update(32'h100, tk_tbl[i] ? 32'h300 : 32'h500, tk_tbl[i]);
            exp_pt  = BTB & pt_tbl[i];
            exp_tgt = exp_pt ? 32'h300 : 32'h104;
            tests_run++;
            if (pc !== 32'h100 || pred_taken !== exp_pt || pred_target !== exp_tgt) begin
                tests_failed++;
                $display("FAIL counter_step_%0d got pc=%h pt=%b tgt=%h want pc=00000100 pt=%b tgt=%h",
                         i, pc, pred_taken, pred_target, exp_pt, exp_tgt);
            end
        end
    endtask

    // Counter is 01 here: a same-cycle taken update must not affect this cycle's choice.
    task automatic test_same_cycle();
        en_n          = 1'b0;
        update_valid  = 1'b1;
        update_pc     = 32'h100;
        update_target = 32'h300;
        update_taken  = 1'b1;
        #1;
        tests_run++;
        if (pred_taken !== 1'b0 || pred_target !== 32'h104) begin
            tests_failed++;
            $display("FAIL same_cycle_pred got pt=%b tgt=%h want pt=0 tgt=00000104", pred_taken, pred_target);
        end
        step();
        update_valid = 1'b0;
        en_n         = 1'b1;
        tests_run++;
        if (pc !== 32'h104) begin
            tests_failed++;
            $display("FAIL same_cycle_next_pc got %h want %h", pc, 32'h104);
        end
        jump(32'h100);
        tests_run++;
        if (pred_taken !== BTB || pred_target !== (BTB ? 32'h300 : 32'h104)) begin
            tests_failed++;
            $display("FAIL same_cycle_after got pt=%b tgt=%h want pt=%b tgt=%h",
                     pred_taken, pred_target, BTB, BTB ? 32'h300 : 32'h104);
        end
    endtask

    task automatic test_alias();
        en_n = 1'b1;
        do_update(32'h140, 32'h600, 1'b1);
        jump(32'h100);
        tests_run++;
        if (pred_taken !== 1'b0 || pred_target !== 32'h104) begin
            tests_failed++;
            $display("FAIL alias_evicted got pt=%b tgt=%h want pt=0 tgt=00000104", pred_taken, pred_target);
        end
        jump(32'h140);
        tests_run++;
        if (pred_taken !== BTB || pred_target !== (BTB ? 32'h600 : 32'h144)) begin
            tests_failed++;
            $display("FAIL alias_new got pt=%b tgt=%h want pt=%b tgt=%h",
                     pred_taken, pred_target, BTB, BTB ? 32'h600 : 32'h144);
        end
        do_update(32'h180, 32'h700, 1'b0);
        tests_run++;
        if (pred_taken !== BTB || pred_target !== (BTB ? 32'h600 : 32'h144)) begin
            tests_failed++;
            $display("FAIL miss_not_taken got pt=%b tgt=%h want pt=%b tgt=%h",
                     pred_taken, pred_target, BTB, BTB ? 32'h600 : 32'h144);
        end
        jump(32'h180);
        tests_run++;
        if (pred_taken !== 1'b0) begin
            tests_failed++;
            $display("FAIL miss_no_alloc got pt=%b want pt=0", pred_taken);
        end
    endtask

    task automatic test_stall_redirect();
        en_n = 1'b1;
        jump(32'h400);
        tests_run++;
        if (pc !== 32'h400) begin
            tests_failed++;
            $display("FAIL redirect_over_stall got %h want %h", pc, 32'h400);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            tests_run++;
            if (pc !== 32'h400 || pcplus4 !== 32'h404) begin
                tests_failed++;
                $display("FAIL stall_%0d got pc=%h p4=%h want pc=00000400 p4=00000404", i, pc, pcplus4);
            end
        end
        en_n = 1'b0;
        jump(32'h800);
        step();
        en_n = 1'b1;
        tests_run++;
        if (pc !== 32'h804) begin
            tests_failed++;
            $display("FAIL redirect_then_run got %h want %h", pc, 32'h804);
        end
    endtask

    task automatic test_wrap();
        en_n = 1'b1;
        jump(32'hFFFF_FFFC);
        tests_run++;
        if (pcplus4 !== 32'h0 || pred_taken !== 1'b0 || pred_target !== 32'h0) begin
            tests_failed++;
            $display("FAIL wrap_outputs got p4=%h pt=%b tgt=%h want p4=00000000 pt=0 tgt=00000000",
                     pcplus4, pred_taken, pred_target);
        end
        en_n = 1'b0;
        step();
        en_n = 1'b1;
        tests_run++;
        if (pc !== 32'h0 || pcplus4 !== 32'h4) begin
            tests_failed++;
            $display("FAIL wrap_next got pc=%h p4=%h want pc=00000000 p4=00000004", pc, pcplus4);
        end
    endtask

    task automatic test_reset_clears();
        en_n = 1'b1;
        jump(32'h140);
        tests_run++;
        if (pred_taken !== BTB) begin
            tests_failed++;
            $display("FAIL pre_reset_hit got pt=%b want pt=%b", pred_taken, BTB);
        end
        @(posedge clk);
        #2;
        update_valid  = 1'b1;
        update_pc     = 32'h100;
        update_target = 32'h900;
        update_taken  = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (pc !== 32'hBFC0_0000 || pred_taken !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid_update got pc=%h pt=%b want pc=bfc00000 pt=0", pc, pred_taken);
        end
        @(negedge clk);
        update_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        jump(32'h140);
        tests_run++;
        if (pred_taken !== 1'b0 || pred_target !== 32'h144) begin
            tests_failed++;
            $display("FAIL reset_cleared_140 got pt=%b tgt=%h want pt=0 tgt=00000144", pred_taken, pred_target);
        end
        jump(32'h100);
        tests_run++;
        if (pred_taken !== 1'b0 || pred_target !== 32'h104) begin
            tests_failed++;
            $display("FAIL reset_cleared_100 got pt=%b tgt=%h want pt=0 tgt=00000104", pred_taken, pred_target);
        end
    endtask

    initial begin
        rst_n         = 1'b1;
        en_n          = 1'b1;
        redirect      = 1'b0;
        redirect_pc   = 32'h0;
        update_valid  = 1'b0;
        update_pc     = 32'h0;
        update_target = 32'h0;
        update_taken  = 1'b0;

        test_reset();
        test_btb_alloc();
        test_counter();
        test_same_cycle();
        test_alias();
        test_stall_redirect();
        test_wrap();
        test_reset_clears();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
